moving_average_filter: RTL and testbench

//  Multi-channel boxcar (moving-average) low-pass filter for the 24-bit signed audio path.

---
 rtl/moving_average_filter_pkg.sv | 8 +
 rtl/moving_average_channel.sv | 55 +++++
 rtl/moving_average_filter.sv | 85 ++++++++
 tb/tb_moving_average_filter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/moving_average_filter_pkg.sv
// Shared defaults for the audio filter blocks: sample width, window size and channel count.
package moving_average_filter_pkg;

    localparam int FILTER_DEFAULT_WIDTH      = 24;
    localparam int FILTER_DEFAULT_LOG2_DEPTH = 3;
    localparam int FILTER_DEFAULT_CHANNELS   = 2;

endpackage

// File: rtl/moving_average_channel.sv
// One channel of the boxcar filter: flop-based history, running sum and floor-shift averager.
module moving_average_channel
    import moving_average_filter_pkg::*;
#(
    parameter int WIDTH      = FILTER_DEFAULT_WIDTH,
    parameter int LOG2_DEPTH = FILTER_DEFAULT_LOG2_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic [LOG2_DEPTH-1:0]   wr_ptr,
    input  logic signed [WIDTH-1:0] sample,
    output logic signed [WIDTH-1:0] avg
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = WIDTH + LOG2_DEPTH;

    logic signed [WIDTH-1:0] hist_q [DEPTH];
    logic signed [WIDTH-1:0] hist_d [DEPTH];
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic signed [SUM_W-1:0] sum_next;
    logic signed [WIDTH-1:0] avg_q, avg_d;

    // Arithmetic shift floors toward -infinity; the quotient always fits WIDTH bits.
    function automatic logic signed [WIDTH-1:0] floor_avg(input logic signed [SUM_W-1:0] s);
        return WIDTH'(s >>> LOG2_DEPTH);
    endfunction

    always_comb begin
        hist_d   = hist_q;
        sum_d    = sum_q;
        avg_d    = avg_q;
        sum_next = sum_q + SUM_W'(sample) - SUM_W'(hist_q[wr_ptr]);
        if (rst || clr) begin
            hist_d = '{default: '0};
            sum_d  = '0;
            avg_d  = '0;
        end else if (in_valid) begin
            hist_d[wr_ptr] = sample;
            sum_d          = sum_next;
            avg_d          = floor_avg(sum_next);
        end
    end

    always_ff @(posedge clk) begin
        hist_q <= hist_d;
        sum_q  <= sum_d;
        avg_q  <= avg_d;
    end

    assign avg = avg_q;

endmodule

// File: rtl/moving_average_filter.sv
// Multi-channel moving-average filter: shared write pointer, fill tracking and output strobe
// around CHANNELS independent per-channel averagers.
module moving_average_filter
    import moving_average_filter_pkg::*;
#(
    parameter int WIDTH      = FILTER_DEFAULT_WIDTH,
    parameter int LOG2_DEPTH = FILTER_DEFAULT_LOG2_DEPTH,
    parameter int CHANNELS   = FILTER_DEFAULT_CHANNELS
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        CLEAR,
    input  logic                        IN_VALID,
    input  logic [CHANNELS*WIDTH-1:0]   IN_DATA,
    output logic                        OUT_VALID,
    output logic [CHANNELS*WIDTH-1:0]   OUT_DATA,
    output logic                        PRIMED
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int CNT_W = LOG2_DEPTH + 1;

    logic                  accept;
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      fill_q, fill_d;
    logic                  primed_q, primed_d;
    logic                  out_valid_q, out_valid_d;

    assign accept = IN_VALID && !RESET && !CLEAR;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        primed_d    = primed_q;
        out_valid_d = 1'b0;
        if (RESET || CLEAR) begin
            wr_ptr_d = '0;
            fill_d   = '0;
            primed_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            if (fill_q != CNT_W'(DEPTH)) begin
                fill_d = fill_q + 1'b1;
            end
            // Rises alongside the output strobe of the DEPTH-th accepted sample.
            if (fill_q == CNT_W'(DEPTH - 1)) begin
                primed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign PRIMED    = primed_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        moving_average_channel #(
            .WIDTH      (WIDTH),
            .LOG2_DEPTH (LOG2_DEPTH)
        ) u_chan (
            .clk      (CLK),
            .rst      (RESET),
            .clr      (CLEAR),
            .in_valid (IN_VALID),
            .wr_ptr   (wr_ptr_q),
            .sample   (IN_DATA[k*WIDTH +: WIDTH]),
            .avg      (OUT_DATA[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter (WIDTH=24, LOG2_DEPTH=3, CHANNELS=2).
module tb_moving_average_filter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        CLEAR = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [47:0] IN_DATA = '0;
    logic        OUT_VALID;
    logic [47:0] OUT_DATA;
    logic        PRIMED;

    int n_checks = 0;
    int n_fail   = 0;

    moving_average_filter #(
        .WIDTH      (24),
        .LOG2_DEPTH (3),
        .CHANNELS   (2)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CLEAR     (CLEAR),
        .IN_VALID  (IN_VALID),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_DATA  (OUT_DATA),
        .PRIMED    (PRIMED)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] ch_out(input int k);
        logic signed [23:0] v;
        v = OUT_DATA[k*24 +: 24];
        return 32'(v);
    endfunction

    // Apply one cycle of inputs; outputs are then sampled 1 ns after the edge.
    task automatic drive(input logic v, input logic signed [23:0] a, input logic signed [23:0] b,
                         input logic r, input logic c);
        IN_VALID = v;
        IN_DATA  = {b, a};
        RESET    = r;
        CLEAR    = c;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        RESET    = 1'b0;
        CLEAR    = 1'b0;
    endtask

    function automatic longint floor_div8(input longint s);
        longint q;
        q = s / 8;
        if ((s % 8 != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    longint hist0 [8];
    longint hist1 [8];
    int     ptr;
    longint s0, s1, v;

    initial begin
        // 1: reset state, then a single sample
        drive(0, 0, 0, 1, 0);
        check_eq("rst_out_valid", OUT_VALID, 0);
        check_eq("rst_primed", PRIMED, 0);
        check_eq("rst_ch0", ch_out(0), 0);
        check_eq("rst_ch1", ch_out(1), 0);
        drive(1, 800, -800, 0, 0);
        check_eq("t1_valid", OUT_VALID, 1);
        check_eq("t1_ch0", ch_out(0), 100);
        check_eq("t1_ch1", ch_out(1), -100);
        check_eq("t1_primed", PRIMED, 0);
        drive(0, 0, 0, 0, 0);
        check_eq("t1_valid_drop", OUT_VALID, 0);
        check_eq("t1_hold_ch0", ch_out(0), 100);

        // 2: warm-up ramp, priming, window slide, channel independence
        drive(0, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            drive(1, 8, 0, 0, 0);
            check_eq($sformatf("t2_ramp%0d", i), ch_out(0), i);
            check_eq($sformatf("t2_ch1_%0d", i), ch_out(1), 0);
            check_eq($sformatf("t2_primed%0d", i), PRIMED, (i == 8) ? 1 : 0);
            check_eq($sformatf("t2_valid%0d", i), OUT_VALID, 1);
        end
        drive(1, 0, 0, 0, 0);
        check_eq("t2_slide", ch_out(0), 7);
        check_eq("t2_slide_primed", PRIMED, 1);

        // 3: floor behaviour for negative values
        drive(0, 0, 0, 1, 0);
        drive(1, -1, 0, 0, 0);
        check_eq("t3_single_neg", ch_out(0), -1);
        drive(0, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            drive(1, -1, 0, 0, 0);
            check_eq($sformatf("t3_neg%0d", i), ch_out(0), -1);
        end

        // 4: full-scale extremes, no wrap at any step
        drive(0, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            drive(1, 24'h7FFFFF, 0, 0, 0);
            check_eq($sformatf("t4_pos%0d", i), ch_out(0), 32'(floor_div8(longint'(i) * 8388607)));
        end
        check_eq("t4_pos_final", ch_out(0), 32'sh007FFFFF);
        for (int i = 1; i <= 8; i++) begin
            drive(1, 24'h800000, 0, 0, 0);
            check_eq($sformatf("t4_neg%0d", i), ch_out(0),
                     32'(floor_div8(longint'(8 - i) * 8388607 - longint'(i) * 8388608)));
        end
        check_eq("t4_neg_final", ch_out(0), -32'sd8388608);
        check_eq("t4_primed", PRIMED, 1);

        // 5: CLEAR mid-stream wins over IN_VALID
        drive(1, 1234, 1234, 0, 1);
        check_eq("t5_clr_valid", OUT_VALID, 0);
        check_eq("t5_clr_primed", PRIMED, 0);
        check_eq("t5_clr_ch0", ch_out(0), 0);
        drive(1, 80, 0, 0, 0);
        check_eq("t5_after_clr", ch_out(0), 10);
        check_eq("t5_after_clr_primed", PRIMED, 0);

        // 6: RESET inside a continuous stream, then a wrap-around run
        for (int i = 0; i < 5; i++) drive(1, 40, -40, 0, 0);
        drive(1, 7, 7, 1, 0);
        check_eq("t6_rst_valid", OUT_VALID, 0);
        check_eq("t6_rst_primed", PRIMED, 0);
        check_eq("t6_rst_ch0", ch_out(0), 0);
        check_eq("t6_rst_ch1", ch_out(1), 0);
        drive(1, 16, 0, 0, 0);
        check_eq("t6_first", ch_out(0), 2);
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            hist0[i] = 0;
            hist1[i] = 0;
        end
        ptr = 0;
        for (int i = 0; i < 20; i++) begin
            v = longint'(i) * 137 - 900;
            hist0[ptr] = v;
            hist1[ptr] = -3 * v + 5;
            ptr = (ptr + 1) % 8;
            s0 = 0;
            s1 = 0;
            for (int j = 0; j < 8; j++) begin
                s0 += hist0[j];
                s1 += hist1[j];
            end
            drive(1, 24'(v), 24'(-3 * v + 5), 0, 0);
            check_eq($sformatf("t6_wrap_ch0_%0d", i), ch_out(0), 32'(floor_div8(s0)));
            check_eq($sformatf("t6_wrap_ch1_%0d", i), ch_out(1), 32'(floor_div8(s1)));
        end
        check_eq("t6_wrap_primed", PRIMED, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
